// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register file's single write port: round-robin between ALU and MEM,
// registered write stage, busy scoreboard and read-after-write hazard flags.
module rf_wb_arbiter #(
  parameter int BUS_WIDTH   = 16,
  parameter bit FIRST_GRANT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 aluValid,
  input  logic [2:0]           aluRd,
  input  logic [BUS_WIDTH-1:0] aluData,
  output logic                 aluReady,
  input  logic                 memValid,
  input  logic [2:0]           memRd,
  input  logic [BUS_WIDTH-1:0] memData,
  output logic                 memReady,
  output logic                 regWrite,
  output logic [2:0]           rd,
  output logic [BUS_WIDTH-1:0] D,
  input  logic                 issueValid,
  input  logic [2:0]           issueRd,
  output logic                 issueReady,
  input  logic [2:0]           rsA,
  input  logic [2:0]           rsB,
  output logic                 hazardA,
  output logic                 hazardB,
  output logic [7:0]           busyVec
);

  logic                 r_ptr;
  logic                 r_regWrite;
  logic [2:0]           r_rd;
  logic [BUS_WIDTH-1:0] r_D;
  logic [7:0]           r_busy;

  logic                 w_aluWins;
  logic                 w_grant;
  logic [2:0]           w_gRd;
  logic [BUS_WIDTH-1:0] w_gData;
  logic [7:0]           w_setMask;
  logic [7:0]           w_clrMask;

  // Readies are forced low while reset is asserted so no transfer can be seen during reset.
  always_comb begin
    w_aluWins  = aluValid && (!memValid || (r_ptr == 1'b0));
    aluReady   = rst_n && w_aluWins;
    memReady   = rst_n && memValid && !w_aluWins;
    w_grant    = aluReady || memReady;
    w_gRd      = aluReady ? aluRd : memRd;
    w_gData    = aluReady ? aluData : memData;
    issueReady = rst_n && issueValid && ((issueRd == 3'd0) || !r_busy[issueRd]);
    w_setMask  = 8'd0;
    w_clrMask  = 8'd0;
    if (issueReady && (issueRd != 3'd0)) begin
      w_setMask = 8'd1 << issueRd;
    end
    if (w_grant) begin
      w_clrMask = 8'd1 << w_gRd;
    end
  end

  // Register 0 grants are consumed without touching the write port; rd/D hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= FIRST_GRANT;
      r_regWrite <= 1'b0;
      r_rd       <= 3'd0;
      r_D        <= '0;
      r_busy     <= 8'd0;
    end else begin
      r_regWrite <= w_grant && (w_gRd != 3'd0);
      if (w_grant) begin
        r_ptr <= aluReady;
      end
      if (w_grant && (w_gRd != 3'd0)) begin
        r_rd <= w_gRd;
        r_D  <= w_gData;
      end
      r_busy <= ((r_busy | w_setMask) & ~w_clrMask) & 8'hFE;
    end
  end

  // A register stays hazardous through the cycle its write sits on the port.
  always_comb begin
    hazardA = (rsA != 3'd0) && (r_busy[rsA] || (r_regWrite && (r_rd == rsA)));
    hazardB = (rsB != 3'd0) && (r_busy[rsB] || (r_regWrite && (r_rd == rsB)));
  end

  assign regWrite = r_regWrite;
  assign rd       = r_rd;
  assign D        = r_D;
  assign busyVec  = r_busy;

endmodule
